// File: rtl/led_fx_driver.sv
// led_fx_driver: post-processes the PIO LED word with global PWM brightness
// and a per-LED blink mask, configured through a small Avalon-MM slave
// (zero-wait write, combinational read).
//
// Optional build macro: LED_FX_FADE_EN (masked LEDs breathe instead of blink).
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   led_in               requested LED state from the PIO out_port
//   address, chipselect,
//   write_n, writedata   Avalon-MM slave write side
//   readdata             Avalon-MM read data (combinational, 0 when not selected)
//   led_out              registered LED pin drive
//   blink_phase          current blink phase (1 = visible)
module led_fx_driver #(
    parameter int unsigned NUM_LEDS = 9,
    parameter int unsigned CLK_DIV  = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                blink_phase
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [7:0]          duty;
    logic [NUM_LEDS-1:0] blink_mask;
    logic [15:0]         blink_half;
    logic [PW-1:0]       presc;
    logic [7:0]          pwm_cnt;
    logic [15:0]         blink_cnt;
    logic                fade_active_c;
    logic                tick_c;
    logic                wr_c;
    logic                half_wr_c;
    logic [NUM_LEDS-1:0] led_next_c;
    logic                unused_wd_c;

    assign wr_c        = chipselect & ~write_n;
    assign half_wr_c   = wr_c && (address == 2'd2);
    assign tick_c      = (presc == PW'(CLK_DIV - 1));
    assign unused_wd_c = ^writedata;

    function automatic logic pwm_on(input logic [7:0] d, input logic [7:0] cnt);
        return (d == 8'hFF) || (cnt < d);
    endfunction

    // Configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty       <= 8'hFF;
            blink_mask <= '0;
            blink_half <= 16'd500;
        end else if (wr_c) begin
            case (address)
                2'd0:    duty       <= writedata[7:0];
                2'd1:    blink_mask <= writedata[NUM_LEDS-1:0];
                2'd2:    blink_half <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // Tick prescaler and free-running PWM counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= tick_c ? '0 : presc + PW'(1);
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // Blink counter; a BLINK_HALF write restarts the phase and beats a tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (half_wr_c || (blink_half == 16'd0)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (tick_c) begin
            if (blink_cnt == blink_half - 16'd1) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

`ifdef LED_FX_FADE_EN
    logic [7:0] fade_duty;
    logic       fade_up;

    assign fade_active_c = (blink_mask != '0);

    // Triangle ramp 0..DUTY..0, one step per tick; lowering DUTY clamps it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fade_duty <= '0;
            fade_up   <= 1'b1;
        end else if (wr_c && (address == 2'd0) && (writedata[7:0] < fade_duty)) begin
            fade_duty <= writedata[7:0];
            fade_up   <= 1'b0;
        end else if (duty == 8'd0) begin
            fade_duty <= '0;
            fade_up   <= 1'b1;
        end else if (tick_c) begin
            if (fade_up) begin
                if (fade_duty >= duty) begin
                    fade_duty <= fade_duty - 8'd1;
                    fade_up   <= 1'b0;
                end else begin
                    fade_duty <= fade_duty + 8'd1;
                end
            end else if (fade_duty == 8'd0) begin
                fade_duty <= 8'd1;
                fade_up   <= 1'b1;
            end else begin
                fade_duty <= fade_duty - 8'd1;
            end
        end
    end

    // Masked LEDs follow the fade ramp and ignore the blink phase
    always_comb begin
        led_next_c = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (blink_mask[i]) begin
                led_next_c[i] = led_in[i] & pwm_on(fade_duty, pwm_cnt);
            end else begin
                led_next_c[i] = led_in[i] & pwm_on(duty, pwm_cnt);
            end
        end
    end
`else
    assign fade_active_c = 1'b0;

    always_comb begin
        led_next_c = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_next_c[i] = led_in[i] & pwm_on(duty, pwm_cnt) &
                            (~blink_mask[i] | blink_phase);
        end
    end
`endif

    // Registered LED drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= '0;
        end else begin
            led_out <= led_next_c;
        end
    end

    // Combinational read mux
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata = 32'(duty);
                2'd1:    readdata = 32'(blink_mask);
                2'd2:    readdata = 32'(blink_half);
                default: readdata = {30'b0, blink_phase, fade_active_c};
            endcase
        end
    end

endmodule

// File: tb/tb_led_fx_driver.sv
// Bench for led_fx_driver: directed steps plus random traffic, checked against
// an arithmetic model (tick/pwm derived from cycle count, phase from tick count).
module tb_led_fx_driver;

    localparam int unsigned NL  = 9;
    localparam int unsigned DIV = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NL-1:0] led_in;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [NL-1:0] led_out;
    logic          blink_phase;

    led_fx_driver #(.NUM_LEDS(NL), .CLK_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .led_in(led_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .led_out(led_out), .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            k;      // clock edges since reset release
    int            ticks;  // ticks since last BLINK_HALF write / reset
    logic [7:0]    m_duty;
    logic [NL-1:0] m_mask;
    logic [15:0]   m_half;
    logic          m_phase;
    logic [7:0]    m_fade;
    logic          m_up;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic on(input logic [7:0] d, input int pc);
        return (d == 8'hFF) || (pc < int'(d));
    endfunction

    function automatic logic [NL-1:0] exp_led(input logic [NL-1:0] li, input int pc);
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) begin
            logic [7:0] d;
            logic       vis;
            d   = m_duty;
            vis = !m_mask[i] || m_phase;
`ifdef LED_FX_FADE_EN
            if (m_mask[i]) begin
                d   = m_fade;
                vis = 1'b1;
            end
`endif
            r[i] = li[i] & on(d, pc) & vis;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic fa;
`ifdef LED_FX_FADE_EN
        fa = (m_mask != '0);
`else
        fa = 1'b0;
`endif
        case (a)
            2'd0:    return 32'(m_duty);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_half);
            default: return {30'b0, m_phase, fa};
        endcase
    endfunction

    task automatic model_reset();
        k = 0; ticks = 0;
        m_duty = 8'hFF; m_mask = '0; m_half = 16'd500; m_phase = 1'b1;
        m_fade = 8'd0; m_up = 1'b1;
    endtask

    // One clock: drive inputs, predict, advance model, compare
    task automatic cycle(input logic [NL-1:0] li, input logic wr, input logic [1:0] a,
                         input logic [31:0] wd);
        logic [NL-1:0] e;
        logic          tk;
        led_in = li; chipselect = wr; write_n = ~wr; address = a; writedata = wd;
        tk = ((k % int'(DIV)) == int'(DIV) - 1);
        e  = exp_led(li, k % 256);
        @(posedge clk);
`ifdef LED_FX_FADE_EN
        if (wr && a == 2'd0 && wd[7:0] < m_fade) begin
            m_fade = wd[7:0]; m_up = 1'b0;
        end else if (m_duty == 8'd0) begin
            m_fade = 8'd0; m_up = 1'b1;
        end else if (tk) begin
            if (m_up && m_fade >= m_duty) m_up = 1'b0;
            else if (!m_up && m_fade == 8'd0) m_up = 1'b1;
            m_fade = m_up ? m_fade + 8'd1 : m_fade - 8'd1;
        end
`endif
        if (wr) begin
            case (a)
                2'd0: m_duty = wd[7:0];
                2'd1: m_mask = wd[NL-1:0];
                2'd2: begin m_half = wd[15:0]; ticks = 0; end
                default: ;
            endcase
        end
        if (!(wr && a == 2'd2) && tk) ticks++;
        k++;
        m_phase = (m_half == 16'd0) ? 1'b1 : (((ticks / int'(m_half)) % 2) == 0);
        #1;
        chk("led_out", 32'(led_out), 32'(e));
        chk("blink_phase", 32'(blink_phase), 32'(m_phase));
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic cs);
        address = a; chipselect = cs; write_n = 1'b1;
        #1;
        chk("readdata", readdata, cs ? exp_rd(a) : 32'd0);
        chipselect = 1'b0;
    endtask

    initial begin
        int hi;
        logic found;
        reset_n = 1'b0; led_in = '0; address = '0; chipselect = 1'b0;
        write_n = 1'b1; writedata = '0;
        model_reset();
        #12;
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_phase", 32'(blink_phase), 32'd1);
        for (int a = 0; a < 4; a++) rd(2'(a), 1'b1);
        @(negedge clk); reset_n = 1'b1;

        // Defaults: full brightness, 1 clk latency
        cycle(9'h1FF, 1'b0, 2'd0, 32'd0);
        chk("dflt_led", 32'(led_out), 32'h1FF);
        rd(2'd0, 1'b1); chk("rd_duty", readdata, 32'h0000_00FF);
        rd(2'd2, 1'b1); chk("rd_half", readdata, 32'h0000_01F4);
        rd(2'd3, 1'b0);

        // Duty 0x40: 64 of 256 on; then duty 0: never on
        cycle(9'h001, 1'b1, 2'd0, 32'h40);
        hi = 0;
        for (int i = 0; i < 256; i++) begin cycle(9'h001, 1'b0, 2'd0, 0); hi += int'(led_out[0]); end
        chk("duty40_count", 32'(hi), 32'd64);
        cycle(9'h001, 1'b1, 2'd0, 32'h00);
        hi = 0;
        for (int i = 0; i < 256; i++) begin cycle(9'h001, 1'b0, 2'd0, 0); hi += int'(led_out[0]); end
        chk("duty0_count", 32'(hi), 32'd0);

        // Blink: half 3, mask 3
        cycle(9'h007, 1'b1, 2'd0, 32'hFF);
        cycle(9'h007, 1'b1, 2'd1, 32'h003);
        cycle(9'h007, 1'b1, 2'd2, 32'd3);
        for (int i = 0; i < 48; i++) cycle(9'h007, 1'b0, 2'd0, 0);

        // BLINK_HALF = 0 while phase low
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_phase == 1'b0) found = 1'b1;
            else cycle(9'h007, 1'b0, 2'd0, 0);
        end
        chk("wait_phase0", 32'(found), 32'd1);
        cycle(9'h007, 1'b1, 2'd2, 32'd0);
        chk("half0_phase", 32'(blink_phase), 32'd1);
        cycle(9'h007, 1'b0, 2'd0, 0);
`ifndef LED_FX_FADE_EN
        chk("half0_led", 32'(led_out), 32'h007);
`endif

        // BLINK_HALF write coincident with a tick: no toggle
        cycle(9'h007, 1'b1, 2'd2, 32'd1);
        while ((k % int'(DIV)) != int'(DIV) - 1) cycle(9'h007, 1'b0, 2'd0, 0);
        cycle(9'h007, 1'b1, 2'd2, 32'd1);
        chk("tick_wr_phase", 32'(blink_phase), 32'd1);
        for (int i = 0; i < 12; i++) cycle(9'h007, 1'b0, 2'd0, 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [1:0]  a;
            logic        w;
            logic [31:0] wd;
            a  = 2'($urandom);
            w  = ($urandom_range(0, 7) == 0);
            wd = (a == 2'd2) ? 32'($urandom_range(0, 5)) : $urandom;
            cycle(NL'($urandom), w, a, wd);
            rd(2'($urandom), 1'($urandom));
        end

        // Asynchronous reset mid-sequence
        cycle(9'h1FF, 1'b1, 2'd1, 32'h1FF);
        #3; reset_n = 1'b0; model_reset();
        #1;
        chk("arst_led", 32'(led_out), 32'd0);
        chk("arst_phase", 32'(blink_phase), 32'd1);
        rd(2'd0, 1'b1); rd(2'd1, 1'b1); rd(2'd2, 1'b1);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 40; i++) cycle(NL'($urandom), 1'b0, 2'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
